ghost_hit_ctrl: RTL
===================

// Module: ghost_hit_ctrl
// PURPOSE
//  Consumer of the chasing-ghost sprite outputs. Detects pixel overlap between the
//  ghost sprite and the Yoshi sprite during each frame, and decides once per frame
//  whether a hit occurred. On a hit it decrements lives and starts an invulnerability
//  window, during which Yoshi blinks. It requests a ghost respawn and raises
//  game-over when no lives remain. Sits between the sprite generators and the
//  score/HUD and top-level game FSM.
// PARAMETERS
//  LIVES_INIT    3    lives after reset/restart (1..7)
//  INVULN_FRAMES 120  frames of invulnerability after a non-fatal hit (1..255)
//  BLINK_BIT     3    bit of invuln counter driving yoshi_blank (0..7)
// PORTS
//  clk           in   1  pixel clock
//  reset         in   1  asynchronous, active-high
//  frame_tick    in   1  1-cycle pulse at end of visible frame (vsync start)
//  yoshi_on      in   1  current pixel belongs to opaque Yoshi sprite
//  ghost_on      in   1  current pixel belongs to opaque ghost sprite
//  restart       in   1  level request to leave game-over
//  lives         out  3  remaining lives
//  hit_pulse     out  1  1-cycle pulse on accepted hit
//  ghost_respawn out  1  1-cycle pulse; ghost must return to its spawn point
//  invuln        out  1  high in INVULN state
//  yoshi_blank   out  1  suppress Yoshi drawing (blink)
//  game_over     out  1  high in DEAD state
// BEHAVIOUR
//  Reset (async): state=ALIVE, lives=LIVES_INIT, hit_latch=0, inv_cnt=0, all pulse
//   and flag outputs=0. A reset asserted mid-frame discards any latched overlap.
//  Overlap: overlap = yoshi_on & ghost_on. hit_latch is set on any clk with overlap.
//   hit_latch is cleared on every frame_tick, in every state.
//  pending = hit_latch | overlap. An overlap in the same cycle as frame_tick counts
//   toward the frame that frame_tick closes.
//  State machine (all transitions on clk with frame_tick=1 unless noted):
//   ALIVE : with pending=1 and lives>1, lives-=1, inv_cnt=INVULN_FRAMES, go INVULN.
//           With pending=1 and lives==1, lives=0, go DEAD.
//           With pending=0, stay.
//   INVULN: pending is ignored. inv_cnt-=1. When inv_cnt==1, go ALIVE with inv_cnt=0.
//   DEAD  : frame_tick has no effect. restart=1 (any cycle, no tick needed) sets
//           lives=LIVES_INIT, clears hit_latch and inv_cnt, and goes to ALIVE.
//  restart is ignored in ALIVE and INVULN.
//  hit_pulse and ghost_respawn are registered. They are high for exactly the one cycle
//   following the frame_tick that accepted the hit, including the fatal hit.
//  invuln = (state==INVULN). game_over = (state==DEAD). Both are registered with the
//   state.
//  yoshi_blank = invuln & inv_cnt[BLINK_BIT]. It is 0 outside INVULN.
//  lives never underflows; it has no saturation above LIVES_INIT.
//  Latency: a hit is visible on the outputs 1 clk after the closing frame_tick.
//  inv_cnt is 8 bits, unsigned, and is decremented only in INVULN.
// TESTING
//  1. Reset, then overlap for 1 clk mid-frame, then frame_tick -> next clk: hit_pulse=1,
//     ghost_respawn=1, lives=2, invuln=1. The following clk: both pulses 0.
//  2. No overlap for 10 frames -> lives stays 3, hit_pulse is never asserted,
//     state stays ALIVE.
//  3. After hit (INVULN_FRAMES=4), overlap every frame -> lives stays 2, invuln falls
//     after the 4th frame_tick. A 5th-frame overlap then gives lives=1.
//  4. Overlap only in the same cycle as frame_tick -> hit accepted, lives decrements.
//     Overlap the cycle after the tick counts for the next frame only.
//  5. lives=1 plus a hit -> lives=0, game_over=1, hit_pulse=1 once. Further ticks with
//     overlap: no change. restart=1 -> lives=3, game_over=0, ALIVE.
//  6. Assert reset mid-INVULN with hit_latch=1 -> lives=3, invuln=0, yoshi_blank=0
//     immediately. The next frame_tick with no overlap produces no hit.
//  7. BLINK_BIT=1 during INVULN -> yoshi_blank toggles every 2 frames and matches
//     inv_cnt[1].

Source files
------------

// File: rtl/ghost_hit_ctrl.sv
// ghost_hit_ctrl
// Purpose: watches the ghost and Yoshi sprite pixels during each frame and
//   decides once per frame whether they touched. An accepted hit decrements
//   lives. If lives remain, it opens an invulnerability window during which
//   Yoshi blinks. Losing the last life enters a game-over state that is left
//   only on a restart request.
// Ports:
//   clk             pixel clock
//   reset           asynchronous, active-high
//   i_frame_tick    1-cycle pulse at end of visible frame
//   i_yoshi_on      current pixel is opaque Yoshi
//   i_ghost_on      current pixel is opaque ghost
//   i_restart       level request to leave game-over
//   o_lives         remaining lives
//   o_hit_pulse     1-cycle pulse after the tick that accepted a hit
//   o_ghost_respawn 1-cycle pulse, ghost returns to spawn (same timing as hit)
//   o_invuln        high while invulnerable
//   o_yoshi_blank   suppress Yoshi drawing (blink phase)
//   o_game_over     high while dead
//
// state     | meaning
// ST_ALIVE  | vulnerable; a pending overlap at frame end costs a life
// ST_INVULN | counting down invulnerability frames, overlaps ignored
// ST_DEAD   | no lives left; waits for restart
module ghost_hit_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_BIT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_tick,
  input  logic       i_yoshi_on,
  input  logic       i_ghost_on,
  input  logic       i_restart,
  output logic [2:0] o_lives,
  output logic       o_hit_pulse,
  output logic       o_ghost_respawn,
  output logic       o_invuln,
  output logic       o_yoshi_blank,
  output logic       o_game_over
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
  localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_lives, w_lives_nxt;
  logic [7:0] r_inv_cnt, w_inv_cnt_nxt;
  logic       r_hit_latch, w_hit_latch_nxt;
  logic       r_hit_pulse, w_hit_pulse_nxt;
  logic       w_overlap;
  logic       w_pending;

  assign w_overlap = i_yoshi_on & i_ghost_on;
  // An overlap coinciding with the tick still belongs to the frame being closed.
  assign w_pending = r_hit_latch | w_overlap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ALIVE;
      r_lives     <= LIVES_RST;
      r_inv_cnt   <= 8'd0;
      r_hit_latch <= 1'b0;
      r_hit_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lives     <= w_lives_nxt;
      r_inv_cnt   <= w_inv_cnt_nxt;
      r_hit_latch <= w_hit_latch_nxt;
      r_hit_pulse <= w_hit_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_inv_cnt_nxt   = r_inv_cnt;
    w_hit_pulse_nxt = 1'b0;
    // The latch tracks overlap within one frame only, so every tick clears it.
    w_hit_latch_nxt = i_frame_tick ? 1'b0 : (r_hit_latch | w_overlap);

    case (r_state)
      ST_ALIVE: begin
        if (i_frame_tick && w_pending) begin
          w_hit_pulse_nxt = 1'b1;
          if (r_lives > 3'd1) begin
            w_lives_nxt   = r_lives - 3'd1;
            w_inv_cnt_nxt = INV_LOAD;
            w_state_nxt   = ST_INVULN;
          end else begin
            w_lives_nxt = 3'd0;
            w_state_nxt = ST_DEAD;
          end
        end
      end
      ST_INVULN: begin
        if (i_frame_tick) begin
          // <= 1 also recovers from a zero count rather than wrapping to 255.
          if (r_inv_cnt <= 8'd1) begin
            w_inv_cnt_nxt = 8'd0;
            w_state_nxt   = ST_ALIVE;
          end else begin
            w_inv_cnt_nxt = r_inv_cnt - 8'd1;
          end
        end
      end
      ST_DEAD: begin
        if (i_restart) begin
          w_lives_nxt     = LIVES_RST;
          w_inv_cnt_nxt   = 8'd0;
          w_hit_latch_nxt = 1'b0;
          w_state_nxt     = ST_ALIVE;
        end
      end
      default: begin
        w_state_nxt = ST_ALIVE;
      end
    endcase
  end

  assign o_lives         = r_lives;
  assign o_hit_pulse     = r_hit_pulse;
  assign o_ghost_respawn = r_hit_pulse;
  assign o_invuln        = (r_state == ST_INVULN);
  assign o_game_over     = (r_state == ST_DEAD);
  assign o_yoshi_blank   = o_invuln & r_inv_cnt[BLINK_BIT];

endmodule
